// File: rtl/sha256_w_mem.sv
// SHA-256 message schedule: 16-word sliding window plus one expansion adder, one {W, round} pair per cycle.
// Zero-cycle ctr->w path; the consumer throttles with next, and w/round hold steady while next is low.
module sha256_w_mem #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] block,
  input  logic         init,
  input  logic         next,
  output logic [31:0]  w,
  output logic [5:0]   round,
  output logic         w_valid,
  output logic         w_last
);

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  logic [31:0] w_mem [16];
  logic [5:0]  ctr;
  logic        valid;
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  assign w_new = sig1(w_mem[14]) + w_mem[9] + sig0(w_mem[1]) + w_mem[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) w_mem[i] <= '0;
      ctr   <= '0;
      valid <= 1'b0;
    end else if (init) begin
      for (int i = 0; i < 16; i++) w_mem[i] <= block[511 - 32*i -: 32];
      ctr   <= '0;
      valid <= 1'b1;
    end else if (next && valid) begin
      if (ctr == LAST) begin
        valid <= 1'b0;
        ctr   <= '0;
      end else begin
        ctr <= ctr + 6'd1;
        // The 15->16 step must not shift: round 16 reads w_new computed from W0..W15.
        if (ctr >= 6'd16) begin
          for (int i = 0; i < 15; i++) w_mem[i] <= w_mem[i+1];
          w_mem[15] <= w_new;
        end
      end
    end
  end

  always_comb begin
    w = '0;
    if (valid) w = (ctr < 6'd16) ? w_mem[ctr[3:0]] : w_new;
  end

  assign round   = valid ? ctr : 6'd0;
  assign w_valid = valid;
  assign w_last  = valid && (ctr == LAST);

endmodule

// File: tb/tb_sha256_w_mem.sv
// Directed bench for sha256_w_mem: hand-computed vectors plus an array-based reference schedule.
module tb_sha256_w_mem;

  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] block;
  logic         init;
  logic         next;
  logic [31:0]  w;
  logic [5:0]   round;
  logic         w_valid;
  logic         w_last;

  int n_cmp = 0;
  int n_err = 0;

  sha256_w_mem #(.ROUNDS(64)) dut (
    .clk(clk), .reset(reset), .block(block), .init(init), .next(next),
    .w(w), .round(round), .w_valid(w_valid), .w_last(w_last)
  );

  always #5 clk = ~clk;

  localparam logic [511:0] ABC  = {32'h61626380, 416'b0, 32'h0, 32'h00000018};
  localparam logic [511:0] ONES = {512{1'b1}};

  typedef struct {
    int          rnd;
    logic [31:0] exp_w;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Straight array expansion, independent of the DUT's sliding window.
  function automatic logic [31:0] ref_word(input logic [511:0] b, input int idx);
    logic [31:0] ws [64];
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) ws[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(ws[i-15], 7) ^ rotr(ws[i-15], 18) ^ (ws[i-15] >> 3);
      s1 = rotr(ws[i-2], 17) ^ rotr(ws[i-2], 19) ^ (ws[i-2] >> 10);
      ws[i] = s1 + ws[i-7] + s0 + ws[i-16];
    end
    return ws[idx];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [511:0] b);
    block = b;
    init  = 1'b1;
    tick();
    init  = 1'b0;
    block = '0;
  endtask

  task automatic advance_to(input int tgt);
    int guard = 0;
    while (!(w_valid && int'(round) == tgt) && guard < 70) begin
      next = 1'b1;
      tick();
      next = 1'b0;
      guard++;
    end
    chk("advance_to", 32'(round), 32'(tgt));
  endtask

  initial begin
    vecs[0] = '{0,  32'h61626380};
    vecs[1] = '{1,  32'h00000000};
    vecs[2] = '{15, 32'h00000018};
    vecs[3] = '{16, 32'h61626380};
    vecs[4] = '{17, 32'h000F0000};
    vecs[5] = '{18, 32'h7DA86405};
    vecs[6] = '{19, 32'h600003C6};

    reset = 1'b1; init = 1'b0; next = 1'b0; block = '0;
    #12;
    chk("rst_w", w, 32'h0);
    chk("rst_round", 32'(round), 32'h0);
    chk("rst_valid", 32'(w_valid), 32'h0);
    chk("rst_last", 32'(w_last), 32'h0);
    reset = 1'b0;
    tick();

    // Table vectors on the "abc" block, stepping with single next pulses.
    start(ABC);
    chk("init_valid", 32'(w_valid), 32'h1);
    for (int k = 0; k < 7; k++) begin
      advance_to(vecs[k].rnd);
      chk($sformatf("abc_w%0d", vecs[k].rnd), w, vecs[k].exp_w);
    end

    // Full block with next held high: w_last only on round 63.
    start(ABC);
    next = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("full_round%0d", i), 32'(round), 32'(i));
      chk($sformatf("full_w%0d", i), w, ref_word(ABC, i));
      chk($sformatf("full_last%0d", i), 32'(w_last), 32'(i == 63));
      tick();
    end
    next = 1'b0;
    chk("end_valid", 32'(w_valid), 32'h0);
    chk("end_round", 32'(round), 32'h0);
    chk("end_w", w, 32'h0);
    for (int i = 0; i < 3; i++) begin
      next = 1'b1;
      tick();
      next = 1'b0;
      chk("idle_next_valid", 32'(w_valid), 32'h0);
      chk("idle_next_round", 32'(round), 32'h0);
      chk("idle_next_w", w, 32'h0);
    end

    // Stalled run must reproduce the same sequence and hold steady while next is low.
    start(ABC);
    for (int i = 0; i < 64; i++) begin
      int gaps;
      gaps = (i == 16) ? 3 : int'($urandom_range(0, 2));
      chk($sformatf("stall_w%0d", i), w, ref_word(ABC, i));
      for (int g = 0; g < gaps; g++) begin
        tick();
        chk($sformatf("stall_hold_w%0d", i), w, ref_word(ABC, i));
        chk($sformatf("stall_hold_round%0d", i), 32'(round), 32'(i));
      end
      next = 1'b1;
      tick();
      next = 1'b0;
    end
    chk("stall_end_valid", 32'(w_valid), 32'h0);

    // Restart at round 40 with all-ones block; init and next together, init wins.
    start(ABC);
    advance_to(40);
    block = ONES;
    init  = 1'b1;
    next  = 1'b1;
    tick();
    init = 1'b0; next = 1'b0; block = '0;
    chk("restart_round", 32'(round), 32'h0);
    chk("restart_w", w, 32'hFFFFFFFF);
    chk("restart_valid", 32'(w_valid), 32'h1);
    advance_to(16);
    chk("ones_w16_hand", w, 32'h203FFFFC);
    chk("ones_w16_model", w, ref_word(ONES, 16));
    advance_to(17);
    chk("ones_w17_model", w, ref_word(ONES, 17));

    // Asynchronous reset mid-cycle during round 20.
    start(ABC);
    advance_to(20);
    chk("pre_rst_w20", w, ref_word(ABC, 20));
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(w_valid), 32'h0);
    chk("async_rst_last", 32'(w_last), 32'h0);
    chk("async_rst_w", w, 32'h0);
    chk("async_rst_round", 32'(round), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      next = 1'b1;
      tick();
      next = 1'b0;
      chk("post_rst_round", 32'(round), 32'h0);
      chk("post_rst_valid", 32'(w_valid), 32'h0);
      chk("post_rst_w", w, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sha256_w_mem.md
Name: sha256_w_mem

Overview:
- Message-schedule generator for the SHA-256 core; sibling feeder of the K-constant ROM.
- Loads one 512-bit block and emits schedule words W0..W63, one per round.
- Drives a round index that goes straight into the K ROM, so the round datapath gets a matching {W, round} pair each cycle.
- 16-word sliding window plus one combinational expansion adder.

Parameters:
ROUNDS, 64, number of W words emitted per block; legal 17..64; 64 for production, smaller only for reduced-round debug.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
block  input  512  message block; W0 = block[511:480] … W15 = block[31:0].
init  input  1  load block, restart schedule at round 0.
next  input  1  consumer accepted current w; advance one round.
w  output  32  current schedule word W[round].
round  output  6  current round index; wires to K ROM round input.
w_valid  output  1  w/round hold a valid pair.
w_last  output  1  w_valid and round == ROUNDS-1.

Behaviour:
- State:
  - w_mem[0..15] 32-bit registers.
  - ctr, 6-bit round counter.
  - valid flag.
- Reset (async, active-high): w_mem all 0, ctr = 0, valid = 0. Outputs: w = 0, round = 0, w_valid = 0, w_last = 0. Reset mid-block abandons the block; nothing resumes.
- init (sampled on rising clk):
  - w_mem[i] <= block[511-32i -: 32]; ctr <= 0; valid <= 1.
  - w_valid = 1 and w = W0 from the next cycle.
  - init has priority over next in the same cycle.
  - init while valid restarts the block.
- Output mux (combinational from state):
  - ctr < 16: w = w_mem[ctr].
  - Otherwise w = w_new.
  - w_new = s1(w_mem[14]) + w_mem[9] + s0(w_mem[1]) + w_mem[0], mod 2^32.
  - s0(x) = rotr7 ^ rotr18 ^ shr3; s1(x) = rotr17 ^ rotr19 ^ shr10.
- next with valid = 1 and no init:
  - ctr < 15: ctr++ only.
  - ctr >= 15 and ctr < ROUNDS-1: ctr++. If ctr >= 16, also shift w_mem[i] <= w_mem[i+1] for i = 0..14 and w_mem[15] <= w_new.
  - The ctr == 15 → 16 step does not shift, so at round 16 w_mem holds W0..W15 and w_new = W16.
  - ctr == ROUNDS-1 (last word consumed): valid <= 0, ctr <= 0, w_mem holds its contents.
- next with valid = 0 is ignored; no state change.
- w_valid = valid; round = ctr while valid, 0 otherwise.
- When w_valid = 0, w is driven 0 (masked), so no stale data reaches the core.
- Throughput and latency:
  - One word per cycle with next held high.
  - A block takes ROUNDS cycles after the init cycle.
  - Zero-cycle latency from ctr to w: combinational only within the expansion adder. The critical path is 4-input add plus rotations.
- block is only sampled on init; it may change freely at any other time.
- ctr never exceeds ROUNDS-1; no wrap beyond 63 is possible.

Test Plan:
- Reset: assert reset asynchronously mid-cycle during round 20 → w_valid, w_last, w and round go 0 immediately. After release, next pulses produce no change.
- "abc" block (0x61626380, then 13 zero words, then 0x00000000, 0x00000018): init then next every cycle →
  - round 0 w = 0x61626380; round 15 w = 0x00000018.
  - round 16 w = 0x61626380; round 17 w = 0x000F0000; round 18 w = 0x7DA86405.
- Same "abc" block with 64 consecutive nexts → w_last high only at round 63. Cycle after: w_valid = 0, round = 0.
- Stalls: random next gaps (e.g. next low 3 cycles at round 16) → w and round stable while stalled. The word sequence is identical to the no-stall run.
- init mid-block at round 40 with a new block B (all words 0xFFFFFFFF) → next cycle round = 0, w = 0xFFFFFFFF. W16 = s1(0xFFFFFFFF) + 0xFFFFFFFF + s0(0xFFFFFFFF) + 0xFFFFFFFF, checked against the reference model. init and next in the same cycle → init wins.
- next with w_valid = 0 after the block ends → no counter movement; w stays 0.
